// File: rtl/set_assoc_data_store_pkg.sv
// Shared cache definitions: FSM state encoding, width helper and default geometry
// (the defaults are shared with the tag array).
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        EVICT = 2'd2
    } state_t;

    localparam int DEF_WAYS       = 4;
    localparam int DEF_SETS       = 8;
    localparam int DEF_LINE_BYTES = 32;
    localparam int DEF_BEAT_BYTES = 8;

    // Index width that stays at least one bit for single-entry dimensions.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/set_assoc_data_store_data_way_bank.sv
// Storage for one cache way: SETS lines of LINE_BYTES bytes, byte-enable write,
// registered line read and an unregistered snapshot port for the eviction buffer.
module data_way_bank
    import cache_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int IW         = width_of(SETS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [IW-1:0]           wr_index,
    input  logic [LINE_BYTES-1:0]   wr_be,
    input  logic [8*LINE_BYTES-1:0] wr_line,
    input  logic                    rd_en,
    input  logic [IW-1:0]           rd_index,
    output logic [8*LINE_BYTES-1:0] rd_line,
    input  logic [IW-1:0]           snap_index,
    output logic [8*LINE_BYTES-1:0] snap_line
);

    logic [8*LINE_BYTES-1:0] mem [SETS];

    // The read register samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) mem[s] <= '0;
            rd_line <= '0;
        end else begin
            if (wr_en) begin
                for (int b = 0; b < LINE_BYTES; b++) begin
                    if (wr_be[b]) mem[wr_index][8*b +: 8] <= wr_line[8*b +: 8];
                end
            end
            if (rd_en) rd_line <= mem[rd_index];
        end
    end

    assign snap_line = mem[snap_index];

endmodule

// File: rtl/set_assoc_data_store.sv
// N-way set-associative cache data store with a 1-cycle read port, single-byte
// stores, and beat-wise line fill / line eviction engines on the memory side.
module set_assoc_data_store
    import cache_pkg::*;
#(
    parameter  int WAYS       = DEF_WAYS,
    parameter  int SETS       = DEF_SETS,
    parameter  int LINE_BYTES = DEF_LINE_BYTES,
    parameter  int BEAT_BYTES = DEF_BEAT_BYTES,
    localparam int WW         = width_of(WAYS),
    localparam int IW         = width_of(SETS),
    localparam int OW         = width_of(LINE_BYTES),
    localparam int NBEATS     = LINE_BYTES / BEAT_BYTES,
    localparam int BW         = width_of(NBEATS),
    localparam int LW         = 8 * LINE_BYTES,
    localparam int DW         = 8 * BEAT_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_en,
    input  logic [WW-1:0] rd_way,
    input  logic [IW-1:0] rd_index,
    input  logic [OW-1:0] rd_offset,
    output logic          rd_valid,
    output logic [7:0]    rd_byte,
    output logic [LW-1:0] rd_line,
    input  logic          st_en,
    input  logic [WW-1:0] st_way,
    input  logic [IW-1:0] st_index,
    input  logic [OW-1:0] st_offset,
    input  logic [7:0]    st_data,
    output logic          st_ready,
    input  logic          fill_start,
    input  logic [WW-1:0] fill_way,
    input  logic [IW-1:0] fill_index,
    input  logic          fill_valid,
    input  logic [DW-1:0] fill_data,
    output logic          fill_ready,
    output logic          fill_done,
    input  logic          evict_start,
    input  logic [WW-1:0] evict_way,
    input  logic [IW-1:0] evict_index,
    output logic          evict_valid,
    output logic [DW-1:0] evict_data,
    input  logic          evict_ready,
    output logic          evict_done,
    output logic          busy
);

    state_t          state, state_next;
    logic [BW-1:0]   beat_cnt, beat_next;
    logic [WW-1:0]   way_q;
    logic [IW-1:0]   index_q;
    logic [LW-1:0]   evict_buf;
    logic            last_beat;
    logic            snap_load, fill_done_next, evict_done_next;
    logic [WAYS-1:0] wr_en;
    logic [IW-1:0]   wr_index;
    logic [LINE_BYTES-1:0] wr_be;
    logic [LW-1:0]   wr_line;
    logic [LW-1:0]   bank_rd   [WAYS];
    logic [LW-1:0]   bank_snap [WAYS];
    logic [LW-1:0]   snap_line;
    logic [WW-1:0]   rd_way_q;
    logic [OW-1:0]   rd_offset_q;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        data_way_bank #(
            .SETS       (SETS),
            .LINE_BYTES (LINE_BYTES)
        ) u_bank (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (wr_en[w]),
            .wr_index   (wr_index),
            .wr_be      (wr_be),
            .wr_line    (wr_line),
            .rd_en      (rd_en),
            .rd_index   (rd_index),
            .rd_line    (bank_rd[w]),
            .snap_index (evict_index),
            .snap_line  (bank_snap[w])
        );
    end

    assign last_beat   = (beat_cnt == BW'(NBEATS - 1));
    assign busy        = (state != IDLE);
    assign st_ready    = (state == IDLE);
    assign fill_ready  = (state == FILL);
    assign evict_valid = (state == EVICT);
    assign evict_data  = evict_buf[int'(beat_cnt) * DW +: DW];
    assign rd_byte     = rd_valid ? rd_line[int'(rd_offset_q) * 8 +: 8] : 8'h00;

    always_comb begin
        rd_line   = '0;
        snap_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (rd_way_q == WW'(w))  rd_line   = bank_rd[w];
            if (evict_way == WW'(w)) snap_line = bank_snap[w];
        end
    end

    // Stores and fills share the bank write port; they never overlap in time.
    always_comb begin
        state_next      = state;
        beat_next       = beat_cnt;
        wr_en           = '0;
        wr_index        = st_index;
        wr_be           = '0;
        wr_line         = {LINE_BYTES{st_data}};
        snap_load       = 1'b0;
        fill_done_next  = 1'b0;
        evict_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (st_en) begin
                    for (int w = 0; w < WAYS; w++) wr_en[w] = (st_way == WW'(w));
                    wr_be[st_offset] = 1'b1;
                end
                if (evict_start) begin
                    state_next = EVICT;
                    snap_load  = 1'b1;
                end else if (fill_start) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                wr_index = index_q;
                wr_line  = {NBEATS{fill_data}};
                if (fill_valid) begin
                    for (int w = 0; w < WAYS; w++) wr_en[w] = (way_q == WW'(w));
                    for (int b = 0; b < LINE_BYTES; b++) wr_be[b] = (BW'(b / BEAT_BYTES) == beat_cnt);
                    if (last_beat) begin
                        beat_next      = '0;
                        state_next     = IDLE;
                        fill_done_next = 1'b1;
                    end else begin
                        beat_next = beat_cnt + BW'(1);
                    end
                end
            end
            EVICT: begin
                if (evict_ready) begin
                    if (last_beat) begin
                        beat_next       = '0;
                        state_next      = IDLE;
                        evict_done_next = 1'b1;
                    end else begin
                        beat_next = beat_cnt + BW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            evict_buf   <= '0;
            fill_done   <= 1'b0;
            evict_done  <= 1'b0;
            rd_valid    <= 1'b0;
            rd_way_q    <= '0;
            rd_offset_q <= '0;
        end else begin
            state      <= state_next;
            beat_cnt   <= beat_next;
            fill_done  <= fill_done_next;
            evict_done <= evict_done_next;
            rd_valid   <= rd_en;
            if (rd_en) begin
                rd_way_q    <= rd_way;
                rd_offset_q <= rd_offset;
            end
            if (snap_load) evict_buf <= snap_line;
        end
    end

    // Target line of the active fill/evict; only meaningful while busy.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (evict_start) begin
                way_q   <= evict_way;
                index_q <= evict_index;
            end else if (fill_start) begin
                way_q   <= fill_way;
                index_q <= fill_index;
            end
        end
    end

endmodule

// File: tb/tb_set_assoc_data_store.sv
// Self-checking bench for set_assoc_data_store: default geometry against a byte-array
// reference model, plus two extra geometries (single-beat and 16-beat lines).
module tb_set_assoc_data_store;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // default geometry 4/8/32/8
    logic rd_en; logic [1:0] rd_way; logic [2:0] rd_index; logic [4:0] rd_offset;
    logic rd_valid; logic [7:0] rd_byte; logic [255:0] rd_line;
    logic st_en; logic [1:0] st_way; logic [2:0] st_index; logic [4:0] st_offset; logic [7:0] st_data; logic st_ready;
    logic fill_start; logic [1:0] fill_way; logic [2:0] fill_index; logic fill_valid; logic [63:0] fill_data;
    logic fill_ready, fill_done;
    logic evict_start; logic [1:0] evict_way; logic [2:0] evict_index; logic evict_valid; logic [63:0] evict_data;
    logic evict_ready, evict_done, busy;

    set_assoc_data_store dut (
        .clk(clk), .reset(reset),
        .rd_en(rd_en), .rd_way(rd_way), .rd_index(rd_index), .rd_offset(rd_offset),
        .rd_valid(rd_valid), .rd_byte(rd_byte), .rd_line(rd_line),
        .st_en(st_en), .st_way(st_way), .st_index(st_index), .st_offset(st_offset), .st_data(st_data),
        .st_ready(st_ready),
        .fill_start(fill_start), .fill_way(fill_way), .fill_index(fill_index),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready), .fill_done(fill_done),
        .evict_start(evict_start), .evict_way(evict_way), .evict_index(evict_index),
        .evict_valid(evict_valid), .evict_data(evict_data), .evict_ready(evict_ready),
        .evict_done(evict_done), .busy(busy)
    );

    // geometry A: 1/2/8/8 (one beat per line)
    logic a_rd_en; logic [0:0] a_rd_way, a_rd_index; logic [2:0] a_rd_offset;
    logic a_rd_valid; logic [7:0] a_rd_byte; logic [63:0] a_rd_line;
    logic a_st_en; logic [0:0] a_st_way, a_st_index; logic [2:0] a_st_offset; logic [7:0] a_st_data; logic a_st_ready;
    logic a_fill_start; logic [0:0] a_fill_way, a_fill_index; logic a_fill_valid; logic [63:0] a_fill_data;
    logic a_fill_ready, a_fill_done;
    logic a_evict_start; logic [0:0] a_evict_way, a_evict_index; logic a_evict_valid; logic [63:0] a_evict_data;
    logic a_evict_ready, a_evict_done, a_busy;

    set_assoc_data_store #(.WAYS(1), .SETS(2), .LINE_BYTES(8), .BEAT_BYTES(8)) dut_a (
        .clk(clk), .reset(reset),
        .rd_en(a_rd_en), .rd_way(a_rd_way), .rd_index(a_rd_index), .rd_offset(a_rd_offset),
        .rd_valid(a_rd_valid), .rd_byte(a_rd_byte), .rd_line(a_rd_line),
        .st_en(a_st_en), .st_way(a_st_way), .st_index(a_st_index), .st_offset(a_st_offset), .st_data(a_st_data),
        .st_ready(a_st_ready),
        .fill_start(a_fill_start), .fill_way(a_fill_way), .fill_index(a_fill_index),
        .fill_valid(a_fill_valid), .fill_data(a_fill_data), .fill_ready(a_fill_ready), .fill_done(a_fill_done),
        .evict_start(a_evict_start), .evict_way(a_evict_way), .evict_index(a_evict_index),
        .evict_valid(a_evict_valid), .evict_data(a_evict_data), .evict_ready(a_evict_ready),
        .evict_done(a_evict_done), .busy(a_busy)
    );

    // geometry B: 8/64/64/4 (sixteen beats per line)
    logic b_rd_en; logic [2:0] b_rd_way; logic [5:0] b_rd_index; logic [5:0] b_rd_offset;
    logic b_rd_valid; logic [7:0] b_rd_byte; logic [511:0] b_rd_line;
    logic b_st_en; logic [2:0] b_st_way; logic [5:0] b_st_index; logic [5:0] b_st_offset; logic [7:0] b_st_data; logic b_st_ready;
    logic b_fill_start; logic [2:0] b_fill_way; logic [5:0] b_fill_index; logic b_fill_valid; logic [31:0] b_fill_data;
    logic b_fill_ready, b_fill_done;
    logic b_evict_start; logic [2:0] b_evict_way; logic [5:0] b_evict_index; logic b_evict_valid; logic [31:0] b_evict_data;
    logic b_evict_ready, b_evict_done, b_busy;

    set_assoc_data_store #(.WAYS(8), .SETS(64), .LINE_BYTES(64), .BEAT_BYTES(4)) dut_b (
        .clk(clk), .reset(reset),
        .rd_en(b_rd_en), .rd_way(b_rd_way), .rd_index(b_rd_index), .rd_offset(b_rd_offset),
        .rd_valid(b_rd_valid), .rd_byte(b_rd_byte), .rd_line(b_rd_line),
        .st_en(b_st_en), .st_way(b_st_way), .st_index(b_st_index), .st_offset(b_st_offset), .st_data(b_st_data),
        .st_ready(b_st_ready),
        .fill_start(b_fill_start), .fill_way(b_fill_way), .fill_index(b_fill_index),
        .fill_valid(b_fill_valid), .fill_data(b_fill_data), .fill_ready(b_fill_ready), .fill_done(b_fill_done),
        .evict_start(b_evict_start), .evict_way(b_evict_way), .evict_index(b_evict_index),
        .evict_valid(b_evict_valid), .evict_data(b_evict_data), .evict_ready(b_evict_ready),
        .evict_done(b_evict_done), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // reference model: plain byte array indexed [way][set][byte]
    logic [7:0] m [4][8][32];

    function automatic logic [255:0] model_line(input int w, input int i);
        logic [255:0] r;
        for (int b = 0; b < 32; b++) r[8*b +: 8] = m[w][i][b];
        return r;
    endfunction

    task automatic model_clear();
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < 8; i++)
                for (int b = 0; b < 32; b++) m[w][i][b] = 8'h00;
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int w, input int i, input int o, input string nm);
        logic [255:0] el;
        el = model_line(w, i);
        rd_en = 1'b1; rd_way = 2'(w); rd_index = 3'(i); rd_offset = 5'(o);
        tick();
        rd_en = 1'b0;
        check({nm, "_valid"}, rd_valid, 1);
        check({nm, "_byte"}, rd_byte, m[w][i][o]);
        check({nm, "_line"}, rd_line, el);
    endtask

    // handshake and done-pulse monitors, sampled away from the active edge
    int fill_hs = 0, fill_done_cnt = 0, evict_done_cnt = 0;
    int a_fill_hs = 0, a_evict_hs = 0, b_fill_hs = 0, b_evict_hs = 0;
    always @(negedge clk) begin
        if (fill_valid && fill_ready) fill_hs++;
        if (fill_done) fill_done_cnt++;
        if (evict_done) evict_done_cnt++;
        if (a_fill_valid && a_fill_ready) a_fill_hs++;
        if (a_evict_valid && a_evict_ready) a_evict_hs++;
        if (b_fill_valid && b_fill_ready) b_fill_hs++;
        if (b_evict_valid && b_evict_ready) b_evict_hs++;
    end

    typedef struct {
        logic st; logic [1:0] sw; logic [2:0] si; logic [4:0] so; logic [7:0] sd;
        logic rd; logic [1:0] rw; logic [2:0] ri; logic [4:0] ro; logic [7:0] eb;
    } vec_t;

    function automatic logic [63:0] ramp_beat(input int k);
        logic [63:0] d;
        for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(k * 8 + j);
        return d;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [10];
        logic [255:0] snap;
        logic [63:0]  a_line;
        logic [511:0] b_line;
        int beat, stall, k, d0, e0;

        reset = 1'b1;
        {rd_en, rd_way, rd_index, rd_offset, st_en, st_way, st_index, st_offset, st_data} = '0;
        {fill_start, fill_way, fill_index, fill_valid, fill_data, evict_start, evict_way, evict_index, evict_ready} = '0;
        {a_rd_en, a_rd_way, a_rd_index, a_rd_offset, a_st_en, a_st_way, a_st_index, a_st_offset, a_st_data} = '0;
        {a_fill_start, a_fill_way, a_fill_index, a_fill_valid, a_fill_data} = '0;
        {a_evict_start, a_evict_way, a_evict_index, a_evict_ready} = '0;
        {b_rd_en, b_rd_way, b_rd_index, b_rd_offset, b_st_en, b_st_way, b_st_index, b_st_offset, b_st_data} = '0;
        {b_fill_start, b_fill_way, b_fill_index, b_fill_valid, b_fill_data} = '0;
        {b_evict_start, b_evict_way, b_evict_index, b_evict_ready} = '0;
        model_clear();
        tick(); tick();
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_byte", rd_byte, 0);
        check("rst_rd_line", rd_line, 0);
        check("rst_fill_ready", fill_ready, 0);
        check("rst_fill_done", fill_done, 0);
        check("rst_evict_valid", evict_valid, 0);
        check("rst_evict_data", evict_data, 0);
        check("rst_evict_done", evict_done, 0);
        check("rst_busy", busy, 0);
        check("rst_st_ready", st_ready, 1);
        reset = 1'b0;
        tick();

        do_read(2, 5, 0, "rd_after_reset");
        check("st_ready_idle", st_ready, 1);

        // store/read table: the read result is checked one cycle after the row is applied
        tbl[0] = '{1'b1, 2'd1, 3'd3, 5'd17, 8'hA5, 1'b1, 2'd1, 3'd3, 5'd17, 8'h00};
        tbl[1] = '{1'b0, 2'd0, 3'd0, 5'd0,  8'h00, 1'b1, 2'd1, 3'd3, 5'd17, 8'hA5};
        tbl[2] = '{1'b0, 2'd0, 3'd0, 5'd0,  8'h00, 1'b1, 2'd1, 3'd3, 5'd16, 8'h00};
        tbl[3] = '{1'b1, 2'd0, 3'd0, 5'd0,  8'h3C, 1'b1, 2'd0, 3'd0, 5'd0,  8'h00};
        tbl[4] = '{1'b0, 2'd0, 3'd0, 5'd0,  8'h00, 1'b1, 2'd0, 3'd0, 5'd0,  8'h3C};
        tbl[5] = '{1'b1, 2'd1, 3'd3, 5'd17, 8'h5A, 1'b1, 2'd1, 3'd3, 5'd18, 8'h00};
        tbl[6] = '{1'b0, 2'd0, 3'd0, 5'd0,  8'h00, 1'b1, 2'd1, 3'd3, 5'd17, 8'h5A};
        tbl[7] = '{1'b0, 2'd0, 3'd0, 5'd0,  8'h00, 1'b0, 2'd1, 3'd3, 5'd17, 8'h00};
        tbl[8] = '{1'b1, 2'd3, 3'd7, 5'd31, 8'h81, 1'b1, 2'd3, 3'd7, 5'd31, 8'h00};
        tbl[9] = '{1'b0, 2'd0, 3'd0, 5'd0,  8'h00, 1'b1, 2'd3, 3'd7, 5'd31, 8'h81};
        for (int n = 0; n < 10; n++) begin
            logic [255:0] el;
            st_en = tbl[n].st; st_way = tbl[n].sw; st_index = tbl[n].si; st_offset = tbl[n].so; st_data = tbl[n].sd;
            rd_en = tbl[n].rd; rd_way = tbl[n].rw; rd_index = tbl[n].ri; rd_offset = tbl[n].ro;
            el = model_line(tbl[n].rw, tbl[n].ri);
            if (tbl[n].st) m[tbl[n].sw][tbl[n].si][tbl[n].so] = tbl[n].sd;
            tick();
            check($sformatf("tbl%0d_valid", n), rd_valid, tbl[n].rd);
            check($sformatf("tbl%0d_byte", n), rd_byte, tbl[n].eb);
            if (tbl[n].rd) check($sformatf("tbl%0d_line", n), rd_line, el);
        end
        st_en = 1'b0; rd_en = 1'b0;

        // random stores and reads against the model
        for (int n = 0; n < 150; n++) begin
            logic [255:0] el;
            logic pr;
            int po;
            st_en = 1'($urandom_range(1)); st_way = 2'($urandom_range(3)); st_index = 3'($urandom_range(7));
            st_offset = 5'($urandom_range(31)); st_data = 8'($urandom);
            rd_en = 1'($urandom_range(1)); rd_way = 2'($urandom_range(3)); rd_index = 3'($urandom_range(7));
            rd_offset = 5'($urandom_range(31));
            pr = rd_en; po = rd_offset;
            el = model_line(rd_way, rd_index);
            if (st_en) m[st_way][st_index][st_offset] = st_data;
            tick();
            check("rand_valid", rd_valid, pr);
            if (pr) begin
                check("rand_byte", rd_byte, el[8*po +: 8]);
                check("rand_line", rd_line, el);
            end
        end
        st_en = 1'b0; rd_en = 1'b0;

        // fill way3/index7 with a gap between beats 1 and 2, and a dropped store
        d0 = fill_done_cnt;
        fill_start = 1'b1; fill_way = 2'd3; fill_index = 3'd7;
        tick();
        fill_start = 1'b0;
        check("fill_busy", busy, 1);
        check("fill_ready", fill_ready, 1);
        check("fill_st_ready", st_ready, 0);
        for (int kk = 0; kk < 4; kk++) begin
            if (kk == 2) begin
                fill_valid = 1'b0;
                st_en = 1'b1; st_way = 2'd3; st_index = 3'd7; st_offset = 5'd9; st_data = 8'hEE;
                tick();
                st_en = 1'b0;
                check("fill_gap_done", fill_done, 0);
            end
            fill_valid = 1'b1; fill_data = ramp_beat(kk);
            tick();
        end
        fill_valid = 1'b0;
        check("fill_done_pulse", fill_done, 1);
        check("fill_busy_end", busy, 0);
        check("fill_hs", fill_hs, 4);
        for (int b = 0; b < 32; b++) m[3][7][b] = 8'(b);
        tick(); tick();
        check("fill_done_count", fill_done_cnt - d0, 1);
        do_read(3, 7, 9, "fill_rd9");

        // evict way3/index7; same-cycle store is excluded from the snapshot
        e0 = evict_done_cnt;
        snap = model_line(3, 7);
        evict_start = 1'b1; evict_way = 2'd3; evict_index = 3'd7;
        st_en = 1'b1; st_way = 2'd3; st_index = 3'd7; st_offset = 5'd0; st_data = 8'h77;
        m[3][7][0] = 8'h77;
        tick();
        evict_start = 1'b0; st_en = 1'b0;
        beat = 0; stall = 0;
        for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
            st_en = (cyc == 2);
            st_way = 2'd3; st_index = 3'd7; st_offset = 5'd8; st_data = 8'hFF;
            check("evict_valid", evict_valid, 1);
            check($sformatf("evict_beat%0d", beat), evict_data, snap[64*beat +: 64]);
            evict_ready = !(beat == 1 && stall < 3);
            if (!evict_ready) stall++;
            else beat++;
            tick();
        end
        evict_ready = 1'b0; st_en = 1'b0;
        check("evict_beats", beat, 4);
        check("evict_stalls", stall, 3);
        check("evict_done_pulse", evict_done, 1);
        check("evict_valid_end", evict_valid, 0);
        check("evict_busy_end", busy, 0);
        tick(); tick();
        check("evict_done_count", evict_done_cnt - e0, 1);
        do_read(3, 7, 8, "evict_rd8");
        do_read(3, 7, 0, "evict_rd0");

        // simultaneous starts: eviction wins
        snap = model_line(0, 0);
        evict_start = 1'b1; evict_way = 2'd0; evict_index = 3'd0;
        fill_start = 1'b1; fill_way = 2'd1; fill_index = 3'd1;
        tick();
        evict_start = 1'b0; fill_start = 1'b0;
        check("prio_evict_valid", evict_valid, 1);
        check("prio_fill_ready", fill_ready, 0);
        evict_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && busy; cyc++) begin
            check("prio_no_fill", fill_ready, 0);
            tick();
        end
        evict_ready = 1'b0;
        check("prio_idle", busy, 0);

        // reset in the middle of a fill aborts it
        d0 = fill_done_cnt;
        fill_start = 1'b1; fill_way = 2'd2; fill_index = 3'd1;
        tick();
        fill_start = 1'b0;
        check("abort_fill_ready", fill_ready, 1);
        fill_valid = 1'b1; fill_data = 64'hDEAD_BEEF_1234_5678;
        tick();
        fill_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        check("abort_busy", busy, 0);
        check("abort_fill_done", fill_done, 0);
        tick(); tick();
        check("abort_done_count", fill_done_cnt - d0, 0);
        do_read(2, 1, 3, "abort_rd");
        do_read(3, 7, 9, "abort_rd_old");

        // geometry A: single-beat round trip
        a_line = {$urandom, $urandom};
        a_fill_start = 1'b1; a_fill_way = 1'b0; a_fill_index = 1'b1;
        tick();
        a_fill_start = 1'b0;
        a_fill_valid = 1'b1; a_fill_data = a_line;
        tick();
        a_fill_valid = 1'b0;
        check("a_fill_done", a_fill_done, 1);
        check("a_busy", a_busy, 0);
        check("a_fill_hs", a_fill_hs, 1);
        a_rd_en = 1'b1; a_rd_way = 1'b0; a_rd_index = 1'b1; a_rd_offset = 3'd5;
        tick();
        a_rd_en = 1'b0;
        check("a_rd_line", a_rd_line, a_line);
        check("a_rd_byte", a_rd_byte, a_line[47:40]);
        a_evict_start = 1'b1; a_evict_way = 1'b0; a_evict_index = 1'b1;
        tick();
        a_evict_start = 1'b0;
        check("a_evict_valid", a_evict_valid, 1);
        check("a_evict_data", a_evict_data, a_line);
        a_evict_ready = 1'b1;
        tick();
        a_evict_ready = 1'b0;
        check("a_evict_done", a_evict_done, 1);
        check("a_evict_valid_end", a_evict_valid, 0);
        check("a_evict_hs", a_evict_hs, 1);

        // geometry B: sixteen-beat round trip with random gaps and back-pressure
        for (int j = 0; j < 16; j++) b_line[32*j +: 32] = $urandom;
        b_fill_start = 1'b1; b_fill_way = 3'd5; b_fill_index = 6'd42;
        tick();
        b_fill_start = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 100 && k < 16; cyc++) begin
            b_fill_valid = ($urandom_range(3) != 0);
            b_fill_data = b_line[32*k +: 32];
            if (b_fill_valid) k++;
            tick();
        end
        b_fill_valid = 1'b0;
        check("b_fill_done", b_fill_done, 1);
        check("b_busy", b_busy, 0);
        check("b_fill_hs", b_fill_hs, 16);
        b_rd_en = 1'b1; b_rd_way = 3'd5; b_rd_index = 6'd42; b_rd_offset = 6'd63;
        tick();
        b_rd_en = 1'b0;
        check("b_rd_line", b_rd_line, b_line);
        check("b_rd_byte", b_rd_byte, b_line[511:504]);
        b_evict_start = 1'b1; b_evict_way = 3'd5; b_evict_index = 6'd42;
        tick();
        b_evict_start = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 100 && k < 16; cyc++) begin
            check("b_evict_valid", b_evict_valid, 1);
            check($sformatf("b_evict_beat%0d", k), b_evict_data, b_line[32*k +: 32]);
            b_evict_ready = 1'($urandom_range(1));
            if (b_evict_ready) k++;
            tick();
        end
        b_evict_ready = 1'b0;
        check("b_evict_done", b_evict_done, 1);
        check("b_evict_valid_end", b_evict_valid, 0);
        check("b_evict_hs", b_evict_hs, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
